mult_stage_sequencer: RTL and testbench

//  Schedules one full-image inference pass through the 28-lane multiplier stage (Mult_Stage).

---
 rtl/mult_stage_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_mult_stage_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_stage_sequencer.sv
// mult_stage_sequencer
//   Schedules one full-image inference pass through the 28-lane Mult_Stage.
//   Walks every (class, row) pair in order, issuing pixel-row and weight-row
//   read addresses, and carries a {valid, first, last, class} tag through a
//   fixed delay line so the tag lines up with the Mult_Stage output.
//
// Optional feature: define SEQ_ABORT_EN to add the Abort input.
//
// Ports
//   clk          in   system clock, rising edge
//   GlobalReset  in   asynchronous active-high reset
//   Start        in   begin a pass (sampled only in IDLE)
//   Hold         in   pause issue while high (ISSUE only)
//   Abort        in   (SEQ_ABORT_EN) cancel the pass in progress
//   Busy         out  pass in progress
//   Done         out  one-cycle pulse once every product has left Mult_Stage
//   Rd_En        out  read strobe to pixel and weight memories
//   Pix_Addr     out  pixel row address (= row)
//   Wgt_Addr     out  weight row address (= class*N_ROWS + row)
//   Mult_Valid   out  Mult_Stage output holds a valid product vector
//   Acc_First    out  with Mult_Valid: row 0 of the class
//   Acc_Last     out  with Mult_Valid: row N_ROWS-1 of the class
//   Acc_Class    out  with Mult_Valid: class index
`timescale 1ns/1ps
module mult_stage_sequencer #(
  parameter int unsigned N_ROWS    = 28,
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned MULT_LAT  = 2,
  parameter int unsigned ROW_AW    = 5,
  parameter int unsigned WGT_AW    = 9,
  parameter int unsigned CLS_W     = 4
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              Start,
  input  logic              Hold,
`ifdef SEQ_ABORT_EN
  input  logic              Abort,
`endif
  output logic              Busy,
  output logic              Done,
  output logic              Rd_En,
  output logic [ROW_AW-1:0] Pix_Addr,
  output logic [WGT_AW-1:0] Wgt_Addr,
  output logic              Mult_Valid,
  output logic              Acc_First,
  output logic              Acc_Last,
  output logic [CLS_W-1:0]  Acc_Class
);

  localparam int unsigned P = MEM_LAT + MULT_LAT;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [ROW_AW-1:0]          row_q, row_d;
  logic [CLS_W-1:0]           cls_q, cls_d;
  logic [WGT_AW-1:0]          wgt_q, wgt_d;

  // Tag delay line; stage i holds the tag issued i+1 cycles ago.
  logic [P-1:0]               pv_q, pv_d;
  logic [P-1:0]               pf_q, pf_d;
  logic [P-1:0]               pl_q, pl_d;
  logic [P-1:0][CLS_W-1:0]    pc_q, pc_d;

  logic                       busy_d, done_d, rd_en_d;
  logic [ROW_AW-1:0]          pix_addr_d;
  logic [WGT_AW-1:0]          wgt_addr_d;
  logic                       mv_d, af_d, al_d;
  logic [CLS_W-1:0]           ac_d;

  logic                       issue;
  logic                       last_row, last_cls, pend, abort;

`ifdef SEQ_ABORT_EN
  assign abort = Abort;
`else
  assign abort = 1'b0;
`endif

  assign last_row = (row_q == ROW_AW'(N_ROWS - 1));
  assign last_cls = (cls_q == CLS_W'(N_CLASSES - 1));
  // The output tag register is not part of the line: once the line is
  // empty the last product is on Mult_Valid this cycle and Done follows.
  assign pend     = |pv_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cls_d      = cls_q;
    wgt_d      = wgt_q;
    issue      = 1'b0;
    rd_en_d    = 1'b0;
    pix_addr_d = Pix_Addr;
    wgt_addr_d = Wgt_Addr;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE: begin
        if (!Hold) begin
          issue = 1'b1;
          if (last_row && last_cls) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pend) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    // Counters always name the next pair to issue; they wrap to 0 after
    // the final pair so a new pass starts clean.
    if (issue) begin
      rd_en_d    = 1'b1;
      pix_addr_d = row_q;
      wgt_addr_d = wgt_q;
      if (last_row) begin
        row_d = '0;
        cls_d = last_cls ? '0 : cls_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
      wgt_d = (last_row && last_cls) ? '0 : wgt_q + 1'b1;
    end

    pv_d[0] = issue;
    pf_d[0] = issue && (row_q == '0);
    pl_d[0] = issue && last_row;
    pc_d[0] = issue ? cls_q : '0;
    for (int unsigned i = 1; i < P; i++) begin
      pv_d[i] = pv_q[i-1];
      pf_d[i] = pf_q[i-1];
      pl_d[i] = pl_q[i-1];
      pc_d[i] = pc_q[i-1];
    end

    mv_d = pv_q[P-1];
    af_d = pf_q[P-1];
    al_d = pl_q[P-1];
    ac_d = pc_q[P-1];

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      row_d   = '0;
      cls_d   = '0;
      wgt_d   = '0;
      rd_en_d = 1'b0;
      pv_d    = '0;
      pf_d    = '0;
      pl_d    = '0;
      pc_d    = '0;
      mv_d    = 1'b0;
      af_d    = 1'b0;
      al_d    = 1'b0;
      ac_d    = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      cls_q      <= '0;
      wgt_q      <= '0;
      pv_q       <= '0;
      pf_q       <= '0;
      pl_q       <= '0;
      pc_q       <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Rd_En      <= 1'b0;
      Pix_Addr   <= '0;
      Wgt_Addr   <= '0;
      Mult_Valid <= 1'b0;
      Acc_First  <= 1'b0;
      Acc_Last   <= 1'b0;
      Acc_Class  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cls_q      <= cls_d;
      wgt_q      <= wgt_d;
      pv_q       <= pv_d;
      pf_q       <= pf_d;
      pl_q       <= pl_d;
      pc_q       <= pc_d;
      Busy       <= busy_d;
      Done       <= done_d;
      Rd_En      <= rd_en_d;
      Pix_Addr   <= pix_addr_d;
      Wgt_Addr   <= wgt_addr_d;
      Mult_Valid <= mv_d;
      Acc_First  <= af_d;
      Acc_Last   <= al_d;
      Acc_Class  <= ac_d;
    end
  end

endmodule

// File: tb/tb_mult_stage_sequencer.sv
`timescale 1ns/1ps
module tb_mult_stage_sequencer;

  localparam int N_ROWS    = 28;
  localparam int N_CLASSES = 10;
  localparam int P         = 3;
  localparam int TOTAL     = N_ROWS * N_CLASSES;

  logic       clk = 1'b0;
  logic       GlobalReset = 1'b0;
  logic       Start = 1'b0;
  logic       Hold = 1'b0;
  logic       Abort = 1'b0;
  logic       Busy, Done, Rd_En, Mult_Valid, Acc_First, Acc_Last;
  logic [4:0] Pix_Addr;
  logic [8:0] Wgt_Addr;
  logic [3:0] Acc_Class;

  mult_stage_sequencer #(
    .N_ROWS(N_ROWS), .N_CLASSES(N_CLASSES), .MEM_LAT(1), .MULT_LAT(2),
    .ROW_AW(5), .WGT_AW(9), .CLS_W(4)
  ) dut (
    .clk(clk), .GlobalReset(GlobalReset), .Start(Start), .Hold(Hold),
`ifdef SEQ_ABORT_EN
    .Abort(Abort),
`endif
    .Busy(Busy), .Done(Done), .Rd_En(Rd_En), .Pix_Addr(Pix_Addr),
    .Wgt_Addr(Wgt_Addr), .Mult_Valid(Mult_Valid), .Acc_First(Acc_First),
    .Acc_Last(Acc_Last), .Acc_Class(Acc_Class)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A pass is the list of issue indices 0..TOTAL-1; index n is row n%N_ROWS
  // of class n/N_ROWS. Each issue schedules a product tag P cycles later.
  typedef struct packed { bit f; bit l; int c; } tag_t;
  tag_t mv_exp [int];
  bit   in_pass = 0;
  int   issued = 0, last_rd = 0, mcyc = 0;
  bit   e_busy = 0, e_done = 0, e_rd = 0, e_mv = 0, e_f = 0, e_l = 0;
  int   e_pix = 0, e_wgt = 0, e_cls = 0;
  bit   ab;

  task automatic model_issue();
    tag_t t;
    e_rd  = 1;
    e_pix = issued % N_ROWS;
    e_wgt = issued;
    t.f = (issued % N_ROWS) == 0;
    t.l = (issued % N_ROWS) == N_ROWS - 1;
    t.c = issued / N_ROWS;
    mv_exp[mcyc + P] = t;
    last_rd = mcyc;
    issued++;
  endtask

  always @(posedge clk or posedge GlobalReset) begin
    ab = Abort;
`ifndef SEQ_ABORT_EN
    ab = 1'b0;
`endif
    if (GlobalReset) begin
      in_pass = 0; issued = 0; mv_exp.delete();
      e_busy = 0; e_done = 0; e_rd = 0; e_mv = 0;
    end else begin
      mcyc++;
      e_rd = 0; e_done = 0;
      if (in_pass && ab) begin
        in_pass = 0; issued = 0; mv_exp.delete();
      end else if (!in_pass) begin
        if (Start) begin in_pass = 1; issued = 0; model_issue(); end
      end else if (issued < TOTAL) begin
        if (!Hold) model_issue();
      end else if (mcyc == last_rd + P + 1) begin
        e_done = 1;
      end else if (mcyc == last_rd + P + 2) begin
        in_pass = 0;
      end
      if (mv_exp.exists(mcyc)) begin
        e_mv = 1; e_f = mv_exp[mcyc].f; e_l = mv_exp[mcyc].l; e_cls = mv_exp[mcyc].c;
        mv_exp.delete(mcyc);
      end else begin
        e_mv = 0;
      end
      e_busy = in_pass;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(Busy), int'(e_busy));
      chk("done", int'(Done), int'(e_done));
      chk("rd_en", int'(Rd_En), int'(e_rd));
      chk("mult_valid", int'(Mult_Valid), int'(e_mv));
      if (e_rd) begin
        chk("pix_addr", int'(Pix_Addr), e_pix);
        chk("wgt_addr", int'(Wgt_Addr), e_wgt);
      end
      if (e_mv) begin
        chk("acc_first", int'(Acc_First), int'(e_f));
        chk("acc_last", int'(Acc_Last), int'(e_l));
        chk("acc_class", int'(Acc_Class), e_cls);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int rd_cnt, rd_first, rd_last, mv_cnt, mv_first, mv_last, n_first, n_last;
  int max_cls, done_cnt, done_cyc, busy_last, wgt_first, pix27, wgt_max;
  int hold_low, w33, w34, p34;

  task automatic run_pass(input int hold_from, input int hold_n, input bit pulse,
                          input int exp_done);
    rd_cnt = 0; rd_first = -1; rd_last = -1; mv_cnt = 0; mv_first = -1; mv_last = -1;
    n_first = 0; n_last = 0; max_cls = -1; done_cnt = 0; done_cyc = -1; busy_last = -1;
    wgt_first = -1; pix27 = 0; wgt_max = -1; hold_low = 0; w33 = -1; w34 = -1; p34 = -1;
    @(posedge clk); #1 Start = 1;
    @(posedge clk); #1;              // edge 0 has sampled Start; now cycle 1
    for (int c = 1; c <= exp_done + 6; c++) begin
      Hold  = (hold_n > 0) && (c >= hold_from) && (c < hold_from + hold_n);
      Start = pulse && (c == 50 || c == exp_done - 1 || c == exp_done);
      @(negedge clk);
      if (Rd_En) begin
        if (rd_cnt == 0) begin rd_first = c; wgt_first = int'(Wgt_Addr); end
        rd_cnt++; rd_last = c;
        if (Pix_Addr == 5'd27) pix27++;
        if (int'(Wgt_Addr) > wgt_max) wgt_max = int'(Wgt_Addr);
      end else if (c >= 28 && c <= 32) hold_low++;
      if (c == 33) w33 = int'(Wgt_Addr);
      if (c == 34) begin w34 = int'(Wgt_Addr); p34 = int'(Pix_Addr); end
      if (Mult_Valid) begin
        if (mv_cnt == 0) mv_first = c;
        mv_cnt++; mv_last = c;
        if (Acc_First) n_first++;
        if (Acc_Last) n_last++;
        if (int'(Acc_Class) > max_cls) max_cls = int'(Acc_Class);
      end
      if (Done) begin done_cnt++; done_cyc = c; end
      if (Busy) busy_last = c;
      @(posedge clk); #1;
    end
    Hold = 0; Start = 0;
  endtask

  task automatic pass_literals(input string tag, input int extra);
    chk({tag, "_rd_cnt"}, rd_cnt, 280);
    chk({tag, "_rd_first"}, rd_first, 1);
    chk({tag, "_rd_last"}, rd_last, 280 + extra);
    chk({tag, "_wgt_first"}, wgt_first, 0);
    chk({tag, "_wgt_max"}, wgt_max, 279);
    chk({tag, "_pix27"}, pix27, 10);
    chk({tag, "_mv_cnt"}, mv_cnt, 280);
    chk({tag, "_mv_first"}, mv_first, 4);
    chk({tag, "_mv_last"}, mv_last, 283 + extra);
    chk({tag, "_n_first"}, n_first, 10);
    chk({tag, "_n_last"}, n_last, 10);
    chk({tag, "_max_cls"}, max_cls, 9);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_cyc, 284 + extra);
    chk({tag, "_busy_last"}, busy_last, 284 + extra);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_busy0"}, int'(Busy), 0);
    chk({tag, "_done0"}, int'(Done), 0);
    chk({tag, "_rd0"}, int'(Rd_En), 0);
    chk({tag, "_pix0"}, int'(Pix_Addr), 0);
    chk({tag, "_wgt0"}, int'(Wgt_Addr), 0);
    chk({tag, "_mv0"}, int'(Mult_Valid), 0);
    chk({tag, "_first0"}, int'(Acc_First), 0);
    chk({tag, "_last0"}, int'(Acc_Last), 0);
    chk({tag, "_cls0"}, int'(Acc_Class), 0);
  endtask

  // Waits for the cycle issuing weight row target; returns with found=0 on timeout.
  task automatic run_until_wgt(input int target, output bit found);
    found = 0;
    @(posedge clk); #1 Start = 1;
    @(posedge clk); #1 Start = 0;
    for (int c = 1; c < 400 && !found; c++) begin
      @(negedge clk);
      if (Rd_En && int'(Wgt_Addr) == target) found = 1;
    end
    chk("wait_wgt_found", int'(found), 1);
  endtask

  task automatic quiet_window(input string tag);
    int mv = 0, dn = 0, by = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (Mult_Valid) mv++;
      if (Done) dn++;
      if (Busy) by++;
    end
    chk({tag, "_mv_after"}, mv, 0);
    chk({tag, "_done_after"}, dn, 0);
    chk({tag, "_busy_after"}, by, 0);
  endtask

  initial begin
    bit found;
    // 1: asynchronous reset with no clock edge
    #2 GlobalReset = 1;
    #1 outputs_zero("por");
    chk_en = 1;
    @(posedge clk); #1 GlobalReset = 0;
    repeat (4) @(negedge clk);
    chk("idle_busy", int'(Busy), 0);

    // 2: plain pass
    run_pass(0, 0, 0, 284);
    pass_literals("plain", 0);
    chk("plain_hold_low", hold_low, 0);

    // 3: Hold for edges 27..31
    run_pass(27, 5, 0, 289);
    pass_literals("hold", 5);
    chk("hold_low", hold_low, 5);
    chk("hold_w33", w33, 27);
    chk("hold_w34", w34, 28);
    chk("hold_p34", p34, 0);

    // 4: Start re-pulsed in ISSUE, entering DONE and in DONE
    run_pass(0, 0, 1, 284);
    pass_literals("restart", 0);
    chk("restart_busy_end", int'(Busy), 0);

    // 5: reset mid-pass at class 3, row 12
    run_until_wgt(96, found);
    chk("rst_pix12", int'(Pix_Addr), 12);
    #2 GlobalReset = 1;
    #1 outputs_zero("midrst");
    @(posedge clk); #1 GlobalReset = 0;
    quiet_window("midrst");
    run_pass(0, 0, 0, 284);
    pass_literals("post_rst", 0);

`ifdef SEQ_ABORT_EN
    // 6: abort at weight row 100
    run_until_wgt(100, found);
    #2 Abort = 1;
    @(posedge clk); #1 Abort = 0;
    @(negedge clk);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_rd", int'(Rd_En), 0);
    quiet_window("abort");
    run_pass(0, 0, 0, 284);
    pass_literals("post_abort", 0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
